uart_tx_framer: RTL
===================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame (range 5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (minimum 2).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tx_valid  input  1  frame request from the upstream producer.
REQ-006 SHALL have port tx_data  input  DATA_WIDTH  payload, sampled on handshake.
REQ-007 SHALL have port tx_ready  output  1  block can accept a frame.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 Handshake SHALL occur when tx_valid && tx_ready; tx_data latched into the shift register that cycle; FSM enters START next cycle.
REQ-013 tx_ready SHALL be 1 only in IDLE; busy SHALL equal !tx_ready.
REQ-014 tx SHALL be 1 in IDLE and STOP, 0 in START, shift-register LSB in DATA, and the parity bit in PARITY.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) that restarts at 0 on every bit boundary.
REQ-016 DATA SHALL send LSB first; shift register shifts right once per bit boundary; bit counter of width $clog2(DATA_WIDTH)+1 leaves DATA after DATA_WIDTH bits.
REQ-017 done SHALL pulse high on the last cycle of STOP only; FSM SHALL be in IDLE the following cycle.
REQ-018 Frame length SHALL be (2+DATA_WIDTH+P)*CLKS_PER_BIT cycles from first START cycle to last STOP cycle, P=1 with parity else 0.
REQ-019 Changes on tx_data or tx_valid while busy SHALL be ignored; no queuing.
REQ-020 Back-to-back: with tx_valid held high, next handshake SHALL occur in the IDLE cycle directly after done, so exactly one idle-high cycle separates frames.

Reset
REQ-021 When arst_n is low at a rising edge, next cycle SHALL give state IDLE, tx=1, tx_ready=1, busy=0, done=0, counters and shift register 0.
REQ-022 Reset mid-frame SHALL abandon the frame without done; no partial-frame resumption.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: PARITY state included, bit = even parity (XOR of the latched tx_data), sent between DATA and STOP.
REQ-024 Macro undefined: PARITY state and parity logic absent; DATA proceeds directly to STOP.

Structure
REQ-025 State enum type and the default DATA_WIDTH/CLKS_PER_BIT constants SHALL live in shared package uart_pkg.
REQ-026 Baud counter SHALL be sub-module uart_baud_cnt (inputs clk, arst_n, clear; output bit_tick on count CLKS_PER_BIT-1).

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4)
REQ-027 Reset held 3 cycles, released -> tx=1, tx_ready=1, busy=0, done=0 every cycle until tx_valid.
REQ-028 Send 0xA5, parity off -> tx = 0,1,0,1,0,0,1,0,1,1 each for 4 cycles; done on cycle 40 after the handshake cycle.
REQ-029 Send 0xA5, UART_TX_PARITY_EN on -> parity bit 0 after bit 7; frame 44 cycles; 0x07 gives parity bit 1.
REQ-030 tx_valid held, data 0x00 then 0xFF -> exactly one tx=1 idle cycle between the first STOP and the second START; both frames correct.
REQ-031 tx_data changes to 0x3C mid-frame of 0xA5 -> serial output remains 0xA5.
REQ-032 arst_n low during DATA bit 3 -> next cycle tx=1, tx_ready=1, no done pulse; the next frame sent after reset is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// State encoding and default frame geometry live here.
package uart_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Wraps on its own at each bit boundary; clear holds it at zero.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] STOP   = ST_STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = ST_PARITY;
`endif

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  bit_tick;
    logic                  handshake;
    logic                  last_bit;

`ifdef UART_TX_PARITY_EN
    logic                  par_bit;
`endif

    assign handshake = tx_valid && tx_ready;
    assign last_bit  = (bit_cnt == BW'(DATA_WIDTH - 1));

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .arst_n   (arst_n),
        .clear    (state == IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (handshake) next_state = START;
            START: if (bit_tick)  next_state = DATA;
            DATA: begin
                if (bit_tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_tick) next_state = STOP;
`endif
            STOP:  if (bit_tick)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state <= next_state;
            if (handshake) begin
                shreg   <= tx_data;
                bit_cnt <= '0;
            end else if (state == DATA && bit_tick) begin
                shreg   <= shreg >> 1;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity comes from the latched word, so late tx_data edits cannot leak in
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            par_bit <= 1'b0;
        end else if (handshake) begin
            par_bit <= ^tx_data;
        end
    end
`endif

    always_comb begin
        tx = 1'b1;
        unique case (1'b1)
            (state == START):  tx = 1'b0;
            (state == DATA):   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
            (state == PARITY): tx = par_bit;
`endif
            default:           tx = 1'b1;
        endcase
    end

    assign tx_ready = (state == IDLE);
    assign busy     = !tx_ready;
    assign done     = (state == STOP) && bit_tick;

endmodule
